// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multdiv_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Register that receives the exception code
  localparam int RSTATUS_REG_DEF    = 30;
  // Exception codes written to the status register
  localparam int MULT_EXC_CODE_DEF  = 4;
  localparam int DIV_EXC_CODE_DEF   = 5;
  // Default BUSY watchdog limit
  localparam int TIMEOUT_CYCLES_DEF = 40;

endpackage

// File: rtl/multdiv_hazard.sv
// Stall generation: back-pressure on issue plus RAW hazard on the pending destination.
// Latency: purely combinational.
// Backpressure: stall is the back-pressure signal itself; no storage.
module multdiv_hazard
  import multdiv_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  busy,
  input  logic [REG_ADDR_W-1:0] pending_rd,
  input  logic [REG_ADDR_W-1:0] hazard_rs,
  input  logic [REG_ADDR_W-1:0] hazard_rt,
  input  logic                  issue_valid,
  input  logic                  issue_ready,
  output logic                  stall
);

  logic raw_hit;

  // r0 is never a real dependency, so it never stalls decode
  assign raw_hit = busy && (pending_rd != '0) &&
                   ((hazard_rs == pending_rd) || (hazard_rt == pending_rd));

  assign stall = (issue_valid && !issue_ready) || raw_hit;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences one MULT/DIV op through the shared multdiv unit and requests its writeback; optional watchdog under MULTDIV_TIMEOUT_EN.
// Latency: accept at N, ctrl pulse at N+1, earliest RDY at N+2, earliest wb_valid at N+3.
// Backpressure: one op in flight; issue_ready only in IDLE, wb_rd/wb_data held until wb_ready.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
`ifdef MULTDIV_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
  parameter int REG_ADDR_W     = 5,
  parameter int RSTATUS_REG    = RSTATUS_REG_DEF,
  parameter int MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_is_div,
  input  logic [31:0]           issue_opA,
  input  logic [31:0]           issue_opB,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] hazard_rs,
  input  logic [REG_ADDR_W-1:0] hazard_rt,
  output logic                  stall,
  output logic                  md_ctrl_MULT,
  output logic                  md_ctrl_DIV,
  output logic [31:0]           md_operandA,
  output logic [31:0]           md_operandB,
  input  logic [31:0]           md_result,
  input  logic                  md_exception,
  input  logic                  md_resultRDY,
`ifdef MULTDIV_TIMEOUT_EN
  output logic                  timeout_flag,
`endif
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  input  logic                  wb_ready
);

  state_t                state, state_next;
  logic [31:0]           op_a, op_b;
  logic [REG_ADDR_W-1:0] rd;
  logic                  is_div;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [31:0]           wb_data_q;
  logic                  capture;
  logic                  capture_exc;
  logic                  timeout;
  logic [31:0]           exc_code;
  logic [REG_ADDR_W-1:0] pending_rd;

  assign exc_code = is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt;

  // Count BUSY cycles; cleared in START so the first BUSY cycle sees 0
  always_ff @(posedge clock) begin
    if (reset)                  busy_cnt <= '0;
    else if (state == ST_START) busy_cnt <= '0;
    else if (state == ST_BUSY)  busy_cnt <= busy_cnt + CNT_W'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th BUSY cycle; a real RDY in that cycle wins
  assign timeout      = (state == ST_BUSY) && !md_resultRDY &&
                        (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout;
`else
  assign timeout = 1'b0;
`endif

  // Next-state and writeback-capture decisions
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    capture_exc = 1'b0;
    case (state)
      ST_IDLE:  if (issue_valid) state_next = ST_START;
      // RDY is stale from the previous op here, so it is not looked at
      ST_START: state_next = ST_BUSY;
      ST_BUSY: begin
        if (md_resultRDY) begin
          capture     = 1'b1;
          capture_exc = md_exception;
          // A clean result for r0 has nowhere to go
          if (!md_exception && (rd == '0)) state_next = ST_IDLE;
          else                             state_next = ST_WB;
        end else if (timeout) begin
          capture     = 1'b1;
          capture_exc = 1'b1;
          state_next  = ST_WB;
        end
      end
      ST_WB:    if (wb_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register plus operand and writeback latches
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      rd        <= '0;
      is_div    <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && issue_valid) begin
        op_a   <= issue_opA;
        op_b   <= issue_opB;
        rd     <= issue_rd;
        is_div <= issue_is_div;
      end
      if (capture) begin
        wb_rd_q   <= capture_exc ? REG_ADDR_W'(RSTATUS_REG) : rd;
        wb_data_q <= capture_exc ? exc_code : md_result;
      end
    end
  end

  assign issue_ready  = (state == ST_IDLE);
  assign md_ctrl_MULT = (state == ST_START) && !is_div;
  assign md_ctrl_DIV  = (state == ST_START) && is_div;
  assign md_operandA  = (state == ST_IDLE) ? 32'd0 : op_a;
  assign md_operandB  = (state == ST_IDLE) ? 32'd0 : op_b;
  assign wb_valid     = (state == ST_WB);
  assign wb_rd        = (state == ST_WB) ? wb_rd_q : '0;
  assign wb_data      = (state == ST_WB) ? wb_data_q : 32'd0;

  // Once captured, the register really being written is the hazard target
  assign pending_rd = (state == ST_WB) ? wb_rd_q : rd;

  multdiv_hazard #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .busy        (state != ST_IDLE),
    .pending_rd  (pending_rd),
    .hazard_rs   (hazard_rs),
    .hazard_rt   (hazard_rt),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .stall       (stall)
  );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: plays the multdiv unit and the register file.
// Expected writebacks come from plain arithmetic on the operands.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_div;
  logic [31:0] issue_opA, issue_opB;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  hazard_rs, hazard_rt;
  logic        stall;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic        md_exception, md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
`ifdef MULTDIV_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_opA    (issue_opA),
    .issue_opB    (issue_opB),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .hazard_rs    (hazard_rs),
    .hazard_rt    (hazard_rt),
    .stall        (stall),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
`ifdef MULTDIV_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Full op: issue, ctrl pulse, BUSY wait of 'delay' cycles, RDY, optional WB with 'hold' refused cycles
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd_i, input int delay, input int hold);
    longint             p;
    logic signed [31:0] lo;
    logic               exc;
    logic [31:0]        res, exp_dat;
    logic [4:0]         exp_rd;
    logic               do_wb;
    // Reference behaviour of the multdiv unit and of the controller's writeback
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? $urandom : a / b;
    end else begin
      p   = longint'(signed'(a)) * longint'(signed'(b));
      lo  = p[31:0];
      exc = (p != longint'(lo));
      res = p[31:0];
    end
    exp_rd  = exc ? 5'd30 : rd_i;
    exp_dat = exc ? (is_div ? 32'd5 : 32'd4) : res;
    do_wb   = exc || (rd_i != 5'd0);

    // IDLE
    hazard_rs = rd_i; hazard_rt = rd_i;
    #1;
    check("idle_ready", issue_ready, 1);
    check("idle_opA", md_operandA, 0);
    check("idle_stall", stall, 0);
    issue_valid = 1'b1; issue_is_div = is_div; issue_opA = a; issue_opB = b; issue_rd = rd_i;
    tick();
    // START: present a stale RDY that must be ignored
    issue_valid = 1'b0; issue_opA = $urandom; issue_opB = $urandom;
    md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hBAD0_0000;
    #1;
    check("start_mult", md_ctrl_MULT, !is_div);
    check("start_div", md_ctrl_DIV, is_div);
    check("start_opA", md_operandA, a);
    check("start_opB", md_operandB, b);
    check("start_ready", issue_ready, 0);
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      check("busy_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
      check("busy_wb", wb_valid, 0);
      if (i == 0) begin
        check("busy_opB", md_operandB, b);
        hazard_rs = rd_i; hazard_rt = rd_i ^ 5'd2;
        #1 check("busy_raw_rs", stall, rd_i != 5'd0);
        hazard_rs = rd_i ^ 5'd1; hazard_rt = rd_i;
        #1 check("busy_raw_rt", stall, rd_i != 5'd0);
        hazard_rt = rd_i ^ 5'd2;
        #1 check("busy_noraw", stall, 0);
        issue_valid = 1'b1;
        #1 check("busy_bp", stall, 1);
        issue_valid = 1'b0;
      end
      tick();
    end
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0; md_result = $urandom;
    #1;
    check("post_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    if (do_wb) begin
      for (int h = 0; h < hold; h++) begin
        check("wb_valid_hold", wb_valid, 1);
        check("wb_rd_hold", wb_rd, exp_rd);
        check("wb_data_hold", wb_data, exp_dat);
        check("wb_ready_in", issue_ready, 0);
        hazard_rs = exp_rd; hazard_rt = exp_rd ^ 5'd1;
        #1 check("wb_raw", stall, 1);
        hazard_rs = exp_rd ^ 5'd2;
        #1 check("wb_noraw", stall, 0);
        issue_valid = 1'b1;
        #1 check("wb_bp", stall, 1);
        issue_valid = 1'b0;
        tick();
        #1;
      end
      wb_ready = 1'b1;
      check("wb_valid", wb_valid, 1);
      check("wb_rd", wb_rd, exp_rd);
      check("wb_data", wb_data, exp_dat);
      tick();
      wb_ready = 1'b0;
      #1;
      check("wb_done_valid", wb_valid, 0);
      check("wb_done_ready", issue_ready, 1);
    end else begin
      check("skip_wb_valid", wb_valid, 0);
      check("skip_idle", issue_ready, 1);
      hazard_rs = 5'd0; hazard_rt = 5'd0;
      #1 check("skip_stall", stall, 0);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0; issue_opA = '0; issue_opB = '0;
    issue_rd = '0; hazard_rs = '0; hazard_rt = '0; md_result = '0; md_exception = 1'b0;
    md_resultRDY = 1'b0; wb_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_ready", issue_ready, 1);
    check("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    check("rst_opA", md_operandA, 0);
    check("rst_opB", md_operandB, 0);
    check("rst_wb", {27'd0, wb_valid, wb_rd}, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_stall", stall, 0);

    // MULT 7*6 -> r3, RDY 16 cycles after the pulse
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 15, 0);
    // DIV by zero -> status register
    run_op(1'b1, 32'd100, 32'd0, 5'd5, 3, 0);
    // Writeback back-pressure and hazards on r3
    run_op(1'b0, 32'd9, 32'd9, 5'd3, 4, 4);
    // r0 destination skips writeback
    run_op(1'b0, 32'd3, 32'd3, 5'd0, 2, 0);

    // Reset in the middle of BUSY
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd11; issue_opB = 32'd12; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hazard_rs = 5'd7; hazard_rt = 5'd7;
    #1;
    check("mid_rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    check("mid_rst_wb", wb_valid, 0);
    check("mid_rst_opA", md_operandA, 0);
    check("mid_rst_ready", issue_ready, 1);
    check("mid_rst_stall", stall, 0);
    md_resultRDY = 1'b1; md_result = 32'd123;
    tick();
    md_resultRDY = 1'b0;
    #1;
    check("late_rdy_wb", wb_valid, 0);
    check("late_rdy_idle", issue_ready, 1);
    run_op(1'b1, 32'd20, 32'd4, 5'd8, 5, 1);

    // Randomized ops
    for (int n = 0; n < 24; n++) begin
      logic        d;
      logic [31:0] a, b;
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 60000);
        b = $urandom_range(0, 60000);
      end else begin
        a = $urandom;
        b = $urandom;
      end
      if (d && ($urandom_range(0, 3) == 0)) b = 32'd0;
      run_op(d, a, b, 5'($urandom_range(0, 31)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 3)));
    end

`ifdef MULTDIV_TIMEOUT_EN
    // Watchdog: MULT with no RDY ever
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd3; issue_opB = 32'd5; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    tick();
    for (int k = 1; k <= 40; k++) begin
      #1 check("to_flag", timeout_flag, k == 40);
      tick();
    end
    #1;
    check("to_flag_off", timeout_flag, 0);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_rd", wb_rd, 30);
    check("to_wb_data", wb_data, 4);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    #1 check("to_idle", issue_ready, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
